tlb_miss_ctrl: RTL and testbench
================================

TLB_MISS_CTRL -- requirements
Module: tlb_miss_ctrl

Interface
REQ-001 Module SHALL run on one clock; reset is asynchronous and active-low; clock and reset are the first ports.
REQ-002 Parameters SHALL come from tlb_params.vh: NUM_WAYS (4), LRU_BITS, VPN_BITS, PPN_BITS.
REQ-003 clk  in  1  system clock.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 miss_valid  in  1 / miss_vpn  in  VPN_BITS  lookup miss request.
REQ-006 miss_ready  out  1  controller can accept a miss.
REQ-007 hit_valid  in  1 / hit_way  in  2  lookup hit notification.
REQ-008 flush  in  1  clear all LRU state.
REQ-009 entry_valid  in  NUM_WAYS  per-way valid bits from TLB storage.
REQ-010 ptw_req_valid  out  1 / ptw_req_vpn  out  VPN_BITS / ptw_req_ready  in  1  page-walk request.
REQ-011 ptw_resp_valid  in  1 / ptw_resp_ppn  in  PPN_BITS / ptw_resp_fault  in  1  page-walk response.
REQ-012 wr_en  out  1 / wr_way  out  2 / wr_vpn  out  VPN_BITS / wr_ppn  out  PPN_BITS  TLB entry write.
REQ-013 miss_done  out  1 / miss_fault  out  1  one-cycle completion pulses.
REQ-014 lru_count  out  NUM_WAYS x LRU_BITS  current LRU counters.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, FILL.
REQ-016 IDLE: miss_ready=1; miss_valid -> latch miss_vpn, go REQ.
REQ-017 REQ: ptw_req_valid=1, ptw_req_vpn=latched vpn, held stable until ptw_req_ready; on handshake -> WAIT.
REQ-018 WAIT: on ptw_resp_valid with fault=1 -> miss_fault pulse, no write, IDLE.
REQ-019 WAIT: on ptw_resp_valid with fault=0 -> latch ppn, latch victim way, go FILL.
REQ-020 Victim selection: lowest-index way with entry_valid=0; if all valid, the minimum-LRU way (lowest index on ties).
REQ-021 FILL: wr_en=1 for exactly one cycle with latched way/vpn/ppn; miss_done pulses the same cycle; next state IDLE.
REQ-022 Miss-to-write latency SHALL be 1 (REQ) + request wait + response wait + 1 (FILL) cycles; back-to-back misses accepted from the cycle after FILL.
REQ-023 LRU touch of way w: if max counter < all-ones, counter[w] <= max+1.
REQ-024 LRU touch at saturation (max = all-ones): every other counter <= counter>>1, counter[w] <= (max>>1)+1.
REQ-025 A hit_valid SHALL touch hit_way in any state except FILL; FILL touches the filled way and ignores hit_valid.
REQ-026 flush SHALL zero all counters next cycle with priority over any touch; FSM state is unaffected; an in-flight walk completes normally.
REQ-027 ptw_resp_valid outside WAIT and miss_valid outside IDLE SHALL be ignored.
REQ-028 wr_*, ptw_req_* data outputs SHALL be zero when their valid is low.

Reset
REQ-029 Reset SHALL force IDLE, all counters 0, latched vpn/ppn/way 0, wr_en=miss_done=miss_fault=ptw_req_valid=0, miss_ready=1.
REQ-030 Reset asserted mid-walk SHALL abandon the walk with no write or pulse; a late response after reset is ignored.

Structure
REQ-031 FSM state encoding and LRU saturation constant SHALL live in the shared tlb_params.vh package.
REQ-032 Minimum/maximum LRU search SHALL reuse the existing tlb_lru sub-module; the invalid-way priority pick stays in tlb_miss_ctrl.

Verification
REQ-033 Reset, all ways invalid, miss vpn=0x12, ready=1 next cycle, resp ppn=0x34 -> wr_en with way 0, vpn 0x12, ppn 0x34, miss_done same cycle, lru_count[0]=1.
REQ-034 All valid, counters {3,1,2,4}, miss with fault=0 -> wr_way=1, counter[1]=5.
REQ-035 Response fault=1 -> miss_fault pulse, wr_en stays 0, counters unchanged, miss_ready=1 next cycle.
REQ-036 Counters {all-ones,2,4,6}, hit way 1 -> {all-ones>>1, (all-ones>>1)+1, 2, 3}.
REQ-037 ptw_req_ready held 0 for 5 cycles -> ptw_req_valid and vpn held stable; flush in WAIT -> counters 0, fill still completes.
REQ-038 rst_n low in WAIT, then response -> no wr_en, no pulse, FSM in IDLE.

Source files
------------

// File: rtl/tlb_miss_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tlb_miss_ctrl_pkg
// Shared TLB miss-handling definitions: geometry parameters, the miss FSM state
// encoding, the LRU saturation constant and the LRU "touch" update rule.
// -----------------------------------------------------------------------------
package tlb_miss_ctrl_pkg;

  localparam int NUM_WAYS = 4;
  localparam int WAY_BITS = 2;
  localparam int LRU_BITS = 4;
  localparam int VPN_BITS = 20;
  localparam int PPN_BITS = 20;

  // Counter value at which a touch must renormalise instead of incrementing.
  localparam logic [LRU_BITS-1:0] LRU_SAT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } miss_state_e;

  typedef logic [NUM_WAYS-1:0][LRU_BITS-1:0] lru_vec_t;

  // Make `way` the most recently used. Below saturation it simply jumps above
  // the current maximum; at saturation every counter is halved first so the
  // relative order is kept while freeing headroom.
  function automatic lru_vec_t lru_touch(input lru_vec_t             cur,
                                         input logic [WAY_BITS-1:0]  way,
                                         input logic [LRU_BITS-1:0]  max_val);
    lru_vec_t nxt;
    nxt = cur;
    if (max_val != LRU_SAT) begin
      nxt[way] = max_val + 1'b1;
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        nxt[i] = cur[i] >> 1;
      end
      nxt[way] = (max_val >> 1) + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tlb_lru.sv
// -----------------------------------------------------------------------------
// tlb_lru
// Combinational search over the LRU counters.
//   cnt_i      : current per-way LRU counters
//   min_way_o  : way holding the smallest counter (lowest index on ties)
//   max_val_o  : largest counter value
// -----------------------------------------------------------------------------
module tlb_lru
  import tlb_miss_ctrl_pkg::*;
(
  input  lru_vec_t            cnt_i,
  output logic [WAY_BITS-1:0] min_way_o,
  output logic [LRU_BITS-1:0] max_val_o
);

  logic [LRU_BITS-1:0] min_val;

  always_comb begin
    min_way_o = '0;
    min_val   = cnt_i[0];
    max_val_o = cnt_i[0];
    for (int i = 1; i < NUM_WAYS; i++) begin
      // Strict compare keeps the lowest index on ties.
      if (cnt_i[i] < min_val) begin
        min_val   = cnt_i[i];
        min_way_o = WAY_BITS'(i);
      end
      if (cnt_i[i] > max_val_o) begin
        max_val_o = cnt_i[i];
      end
    end
  end

endmodule

// File: rtl/tlb_miss_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_miss_ctrl
// TLB miss controller: accepts a lookup miss, issues a page-table-walk request,
// waits for the response and writes the translation into a victim way. Keeps
// per-way LRU counters updated by hits and fills.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   miss_valid/miss_vpn, miss_ready    miss request in
//   hit_valid/hit_way                  lookup hit notification (LRU touch)
//   flush                              clear all LRU counters
//   entry_valid                        per-way valid bits from TLB storage
//   ptw_req_valid/vpn, ptw_req_ready   page-walk request out
//   ptw_resp_valid/ppn/fault           page-walk response in
//   wr_en/wr_way/wr_vpn/wr_ppn         TLB entry write
//   miss_done, miss_fault              one-cycle completion pulses
//   lru_count                          current LRU counters
// -----------------------------------------------------------------------------
module tlb_miss_ctrl
  import tlb_miss_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_valid,
  input  logic [VPN_BITS-1:0] miss_vpn,
  output logic                miss_ready,
  input  logic                hit_valid,
  input  logic [WAY_BITS-1:0] hit_way,
  input  logic                flush,
  input  logic [NUM_WAYS-1:0] entry_valid,
  output logic                ptw_req_valid,
  output logic [VPN_BITS-1:0] ptw_req_vpn,
  input  logic                ptw_req_ready,
  input  logic                ptw_resp_valid,
  input  logic [PPN_BITS-1:0] ptw_resp_ppn,
  input  logic                ptw_resp_fault,
  output logic                wr_en,
  output logic [WAY_BITS-1:0] wr_way,
  output logic [VPN_BITS-1:0] wr_vpn,
  output logic [PPN_BITS-1:0] wr_ppn,
  output logic                miss_done,
  output logic                miss_fault,
  output lru_vec_t            lru_count
);

  miss_state_e         state_q, state_d;
  logic [VPN_BITS-1:0] vpn_q, vpn_d;
  logic [PPN_BITS-1:0] ppn_q, ppn_d;
  logic [WAY_BITS-1:0] way_q, way_d;
  lru_vec_t            lru_q, lru_d;

  logic [WAY_BITS-1:0] lru_min_way;
  logic [LRU_BITS-1:0] lru_max;
  logic [WAY_BITS-1:0] victim;
  logic                invalid_found;
  logic                touch_en;
  logic [WAY_BITS-1:0] touch_way;

  tlb_lru u_lru (
    .cnt_i     (lru_q),
    .min_way_o (lru_min_way),
    .max_val_o (lru_max)
  );

  // Empty ways are always preferred; only a full set falls back to LRU.
  always_comb begin
    victim        = lru_min_way;
    invalid_found = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!invalid_found && !entry_valid[i]) begin
        victim        = WAY_BITS'(i);
        invalid_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vpn_q   <= '0;
      ppn_q   <= '0;
      way_q   <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      vpn_q   <= vpn_d;
      ppn_q   <= ppn_d;
      way_q   <= way_d;
      lru_q   <= lru_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    vpn_d         = vpn_q;
    ppn_d         = ppn_q;
    way_d         = way_q;
    miss_ready    = 1'b0;
    ptw_req_valid = 1'b0;
    ptw_req_vpn   = '0;
    wr_en         = 1'b0;
    wr_way        = '0;
    wr_vpn        = '0;
    wr_ppn        = '0;
    miss_done     = 1'b0;
    miss_fault    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          vpn_d   = miss_vpn;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        ptw_req_valid = 1'b1;
        ptw_req_vpn   = vpn_q;
        if (ptw_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ptw_resp_valid) begin
          if (ptw_resp_fault) begin
            miss_fault = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            // Victim is frozen here so hits during FILL cannot move it.
            ppn_d   = ptw_resp_ppn;
            way_d   = victim;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        wr_en     = 1'b1;
        wr_way    = way_q;
        wr_vpn    = vpn_q;
        wr_ppn    = ppn_q;
        miss_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The fill owns the LRU touch port in FILL; hits are dropped that cycle.
  always_comb begin
    touch_en  = 1'b0;
    touch_way = hit_way;
    if (state_q == ST_FILL) begin
      touch_en  = 1'b1;
      touch_way = way_q;
    end else if (hit_valid) begin
      touch_en  = 1'b1;
    end
    lru_d = lru_q;
    if (flush) begin
      lru_d = '0;
    end else if (touch_en) begin
      lru_d = lru_touch(lru_q, touch_way, lru_max);
    end
  end

  assign lru_count = lru_q;

endmodule

// File: tb/tb_tlb_miss_ctrl.sv
module tb_tlb_miss_ctrl;
  import tlb_miss_ctrl_pkg::*;

  localparam int LMAX = (1 << LRU_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                miss_valid;
  logic [VPN_BITS-1:0] miss_vpn;
  logic                miss_ready;
  logic                hit_valid;
  logic [WAY_BITS-1:0] hit_way;
  logic                flush;
  logic [NUM_WAYS-1:0] entry_valid;
  logic                ptw_req_valid;
  logic [VPN_BITS-1:0] ptw_req_vpn;
  logic                ptw_req_ready;
  logic                ptw_resp_valid;
  logic [PPN_BITS-1:0] ptw_resp_ppn;
  logic                ptw_resp_fault;
  logic                wr_en;
  logic [WAY_BITS-1:0] wr_way;
  logic [VPN_BITS-1:0] wr_vpn;
  logic [PPN_BITS-1:0] wr_ppn;
  logic                miss_done;
  logic                miss_fault;
  lru_vec_t            lru_count;

  int n_checks = 0;
  int n_fail   = 0;
  int mlru[NUM_WAYS];

  tlb_miss_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_ready(miss_ready),
    .hit_valid(hit_valid), .hit_way(hit_way), .flush(flush),
    .entry_valid(entry_valid),
    .ptw_req_valid(ptw_req_valid), .ptw_req_vpn(ptw_req_vpn), .ptw_req_ready(ptw_req_ready),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_fault(ptw_resp_fault),
    .wr_en(wr_en), .wr_way(wr_way), .wr_vpn(wr_vpn), .wr_ppn(wr_ppn),
    .miss_done(miss_done), .miss_fault(miss_fault), .lru_count(lru_count)
  );

  always #5 clk = ~clk;

  // Reference model: counters as plain integers
  function automatic void mreset();
    for (int i = 0; i < NUM_WAYS; i++) mlru[i] = 0;
  endfunction

  function automatic void mtouch(input int w);
    int mx;
    mx = 0;
    for (int i = 0; i < NUM_WAYS; i++) if (mlru[i] > mx) mx = mlru[i];
    if (mx < LMAX) begin
      mlru[w] = mx + 1;
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) if (i != w) mlru[i] = mlru[i] / 2;
      mlru[w] = mx / 2 + 1;
    end
  endfunction

  function automatic int mvictim(input logic [NUM_WAYS-1:0] ev);
    int best;
    for (int i = 0; i < NUM_WAYS; i++) if (!ev[i]) return i;
    best = 0;
    for (int i = 1; i < NUM_WAYS; i++) if (mlru[i] < mlru[best]) best = i;
    return best;
  endfunction

  // Advance one clock and apply what the inputs of the finished cycle mean.
  task automatic edge_upd(input bit h, input int hw, input bit fl, input bit fill, input int fw);
    @(posedge clk);
    #1;
    if (fl) mreset();
    else if (fill) mtouch(fw);
    else if (h) mtouch(hw);
  endtask

  task automatic idle_inputs();
    miss_valid = 0; miss_vpn = '0; hit_valid = 0; hit_way = '0; flush = 0;
    ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_ppn = '0; ptw_resp_fault = 0;
  endtask

  task automatic drive_hit(input int w);
    hit_valid = 1; hit_way = WAY_BITS'(w);
    edge_upd(1, w, 0, 0, 0);
    hit_valid = 0;
  endtask

  task automatic drive_flush();
    flush = 1;
    edge_upd(0, 0, 1, 0, 0);
    flush = 0;
  endtask

  // One complete miss transaction; stalls, random hits and stray inputs are injected.
  task automatic do_miss(input logic [VPN_BITS-1:0] vpn, input int req_wait, input int resp_wait,
                         input logic [PPN_BITS-1:0] ppn, input bit fault,
                         input logic [NUM_WAYS-1:0] ev, input bit rnd, input bit flush_wait,
                         output int got_way);
    bit h, fl, exp_f;
    int hw, exp_way;
    got_way = -1;
    exp_way = 0;
    entry_valid = ev;
    h = rnd && ($urandom_range(0, 1) == 1); hw = $urandom_range(0, 3);
    hit_valid = h; hit_way = WAY_BITS'(hw);
    miss_valid = 1; miss_vpn = vpn;
    #1;
    n_checks++;
    if (miss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b expected 1", miss_ready);
    end
    edge_upd(h, hw, 0, 0, 0);
    for (int i = 0; i <= req_wait; i++) begin
      h = rnd && ($urandom_range(0, 1) == 1); hw = $urandom_range(0, 3);
      hit_valid = h; hit_way = WAY_BITS'(hw);
      miss_valid = rnd && ($urandom_range(0, 1) == 1); miss_vpn = VPN_BITS'($urandom);
      ptw_resp_valid = rnd && ($urandom_range(0, 1) == 1);
      ptw_resp_ppn = PPN_BITS'($urandom); ptw_resp_fault = ($urandom_range(0, 1) == 1);
      ptw_req_ready = (i == req_wait);
      #1;
      n_checks++;
      if ({ptw_req_valid, ptw_req_vpn, miss_ready, wr_en} !== {1'b1, vpn, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL req_hold cycle %0d: got valid=%b vpn=%h ready=%b wr_en=%b, expected valid=1 vpn=%h ready=0 wr_en=0",
                 i, ptw_req_valid, ptw_req_vpn, miss_ready, wr_en, vpn);
      end
      edge_upd(h, hw, 0, 0, 0);
    end
    ptw_req_ready = 0;
    for (int i = 0; i <= resp_wait; i++) begin
      h = rnd && ($urandom_range(0, 1) == 1); hw = $urandom_range(0, 3);
      hit_valid = h; hit_way = WAY_BITS'(hw);
      miss_valid = rnd && ($urandom_range(0, 1) == 1); miss_vpn = VPN_BITS'($urandom);
      fl = flush_wait && (i == 0);
      flush = fl;
      ptw_resp_valid = (i == resp_wait);
      ptw_resp_ppn = (i == resp_wait) ? ppn : PPN_BITS'($urandom);
      ptw_resp_fault = (i == resp_wait) ? fault : ($urandom_range(0, 1) == 1);
      if (i == resp_wait) exp_way = mvictim(ev);
      exp_f = (i == resp_wait) && fault;
      #1;
      n_checks++;
      if ({ptw_req_valid, ptw_req_vpn, wr_en, wr_way, wr_vpn, wr_ppn, miss_done} !== '0) begin
        n_fail++;
        $display("FAIL wait_quiet cycle %0d: got req_valid=%b req_vpn=%h wr_en=%b wr_way=%0d wr_vpn=%h wr_ppn=%h done=%b, expected all 0",
                 i, ptw_req_valid, ptw_req_vpn, wr_en, wr_way, wr_vpn, wr_ppn, miss_done);
      end
      n_checks++;
      if (miss_fault !== exp_f) begin
        n_fail++;
        $display("FAIL wait_fault cycle %0d: got miss_fault=%b expected %b", i, miss_fault, exp_f);
      end
      edge_upd(h, hw, fl, 0, 0);
    end
    flush = 0; ptw_resp_valid = 0; ptw_resp_fault = 0; ptw_resp_ppn = '0;
    if (!fault) begin
      h = rnd && ($urandom_range(0, 1) == 1); hw = $urandom_range(0, 3);
      hit_valid = h; hit_way = WAY_BITS'(hw);
      #1;
      n_checks++;
      if ({wr_en, miss_done, miss_fault, wr_way, wr_vpn, wr_ppn} !==
          {1'b1, 1'b1, 1'b0, WAY_BITS'(exp_way), vpn, ppn}) begin
        n_fail++;
        $display("FAIL fill_write: got wr_en=%b done=%b fault=%b way=%0d vpn=%h ppn=%h, expected 1 1 0 way=%0d vpn=%h ppn=%h",
                 wr_en, miss_done, miss_fault, wr_way, wr_vpn, wr_ppn, exp_way, vpn, ppn);
      end
      got_way = int'(wr_way);
      edge_upd(h, hw, 0, 1, exp_way);
    end
    idle_inputs();
    #1;
    n_checks++;
    if ({miss_ready, wr_en, miss_done, miss_fault, ptw_req_valid} !== 5'b10000) begin
      n_fail++;
      $display("FAIL post_idle: got ready=%b wr_en=%b done=%b fault=%b req_valid=%b, expected 1 0 0 0 0",
               miss_ready, wr_en, miss_done, miss_fault, ptw_req_valid);
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      n_checks++;
      if (lru_count[i] !== LRU_BITS'(mlru[i])) begin
        n_fail++;
        $display("FAIL post_lru[%0d]: got %0d expected %0d", i, lru_count[i], mlru[i]);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    entry_valid = '0;
    rst_n = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({miss_ready, wr_en, miss_done, miss_fault, ptw_req_valid, ptw_req_vpn, wr_way, wr_vpn, wr_ppn} !=
        {1'b1, {(4 + VPN_BITS * 2 + WAY_BITS + PPN_BITS){1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b wr_en=%b done=%b fault=%b req_valid=%b, expected 1 0 0 0 0",
               miss_ready, wr_en, miss_done, miss_fault, ptw_req_valid);
    end
    n_checks++;
    if (lru_count !== '0) begin
      n_fail++;
      $display("FAIL reset_lru: got %h expected 0", lru_count);
    end
    rst_n = 1;
    @(posedge clk); #1;
    n_checks++;
    if (miss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", miss_ready);
    end
  endtask

  task automatic test_fill_invalid();
    int w;
    do_miss(20'h00012, 0, 0, 20'h00034, 0, 4'b0000, 0, 0, w);
    n_checks++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL invalid_way: got %0d expected 0", w);
    end
    n_checks++;
    if (lru_count !== {4'd0, 4'd0, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL invalid_lru: got %h expected 0001", lru_count);
    end
  endtask

  task automatic test_lru_victim();
    int w;
    int expv[NUM_WAYS] = '{3, 1, 2, 4};
    drive_flush();
    drive_hit(1); drive_hit(2); drive_hit(0); drive_hit(3);
    for (int i = 0; i < NUM_WAYS; i++) begin
      n_checks++;
      if (lru_count[i] !== LRU_BITS'(expv[i])) begin
        n_fail++;
        $display("FAIL lru_setup[%0d]: got %0d expected %0d", i, lru_count[i], expv[i]);
      end
    end
    do_miss(20'hABCDE, 1, 1, 20'h55555, 0, 4'b1111, 0, 0, w);
    n_checks++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL lru_victim_way: got %0d expected 1", w);
    end
    n_checks++;
    if (lru_count[1] !== 4'd5) begin
      n_fail++;
      $display("FAIL lru_victim_cnt: got %0d expected 5", lru_count[1]);
    end
  endtask

  task automatic test_fault();
    int w;
    do_miss(20'h0F00D, 0, 2, 20'h12345, 1, 4'b1111, 0, 0, w);
    n_checks++;
    if (lru_count !== {4'd4, 4'd2, 4'd5, 4'd3}) begin
      n_fail++;
      $display("FAIL fault_lru: got %h expected 4253", lru_count);
    end
  endtask

  task automatic test_saturation();
    drive_flush();
    drive_hit(1); drive_hit(1); drive_hit(2); drive_hit(2); drive_hit(3); drive_hit(3);
    repeat (9) drive_hit(0);
    n_checks++;
    if (lru_count !== {4'd6, 4'd4, 4'd2, 4'd15}) begin
      n_fail++;
      $display("FAIL sat_setup: got %h expected 642f", lru_count);
    end
    drive_hit(1);
    n_checks++;
    if (lru_count !== {4'd3, 4'd2, 4'd8, 4'd7}) begin
      n_fail++;
      $display("FAIL sat_touch: got %h expected 3287", lru_count);
    end
  endtask

  task automatic test_stall_flush();
    int w;
    do_miss(20'h7A5C3, 5, 2, 20'h0BEEF, 0, 4'b1111, 0, 1, w);
    n_checks++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL flush_way: got %0d expected 0", w);
    end
    n_checks++;
    if (lru_count !== {4'd0, 4'd0, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL flush_lru: got %h expected 0001", lru_count);
    end
  endtask

  task automatic test_reset_midwalk();
    entry_valid = 4'b0000;
    miss_valid = 1; miss_vpn = 20'h11111;
    edge_upd(0, 0, 0, 0, 0);
    miss_valid = 0; ptw_req_ready = 1;
    edge_upd(0, 0, 0, 0, 0);
    ptw_req_ready = 0;
    rst_n = 0; mreset();
    #2;
    rst_n = 1;
    ptw_resp_valid = 1; ptw_resp_ppn = 20'h22222; ptw_resp_fault = 0;
    #1;
    n_checks++;
    if ({wr_en, miss_done, miss_fault, miss_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL midwalk_resp: got wr_en=%b done=%b fault=%b ready=%b expected 0 0 0 1", wr_en, miss_done, miss_fault, miss_ready);
    end
    edge_upd(0, 0, 0, 0, 0);
    ptw_resp_valid = 0;
    #1;
    n_checks++;
    if ({wr_en, miss_done, miss_fault, miss_ready, ptw_req_valid} !== 5'b00010) begin
      n_fail++;
      $display("FAIL midwalk_after: got wr_en=%b done=%b fault=%b ready=%b req_valid=%b expected 0 0 0 1 0",
               wr_en, miss_done, miss_fault, miss_ready, ptw_req_valid);
    end
    n_checks++;
    if (lru_count !== '0) begin
      n_fail++;
      $display("FAIL midwalk_lru: got %h expected 0", lru_count);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_miss(20'h00001, 0, 0, 20'h00010, 0, 4'b0011, 0, 0, w);
    do_miss(20'h00002, 0, 0, 20'h00020, 0, 4'b0111, 0, 0, w);
    n_checks++;
    if (w != 3) begin
      n_fail++;
      $display("FAIL b2b_way: got %0d expected 3", w);
    end
  endtask

  task automatic test_random();
    int w;
    logic [NUM_WAYS-1:0] ev;
    for (int n = 0; n < 40; n++) begin
      ev = ($urandom_range(0, 1) == 1) ? 4'b1111 : NUM_WAYS'($urandom);
      do_miss(VPN_BITS'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), PPN_BITS'($urandom),
              ($urandom_range(0, 3) == 0), ev, 1, ($urandom_range(0, 7) == 0), w);
      if ($urandom_range(0, 2) == 0) drive_hit($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_fill_invalid();
    test_lru_victim();
    test_fault();
    test_saturation();
    test_stall_flush();
    test_reset_midwalk();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
